// File: rtl/reflet_gpio_scanner.sv
// reflet_gpio_scanner
// Sequences an addressable single-bit IO port. It periodically scans every
// input line into a snapshot register, flags lines whose level changed since
// the previous snapshot, and arbitrates single-line output writes between
// scans.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   enable               allows periodic scans to start (writes are always served)
//   io_addr              line index presented to the IO block
//   io_gpi_read          input level of line io_addr (combinational, same cycle)
//   io_gpo_write         value to store into output line io_addr
//   io_edit_gpo          one-cycle store strobe for io_gpo_write
//   snapshot             last committed scan result, bit k = line k
//   pending, change_irq  changed-line mask and its OR
//   irq_ack              one-cycle pulse clearing pending
//   wr_req/wr_idx/wr_val write request, held until wr_ack
//   wr_ack               one-cycle write completion pulse
//   busy                 high while scanning or writing
module reflet_gpio_scanner #(
  parameter int number_of_io = 16,
  parameter int addr_size    = 6,
  parameter int scan_period  = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  output logic [addr_size-1:0]    io_addr,
  input  logic                    io_gpi_read,
  output logic                    io_gpo_write,
  output logic                    io_edit_gpo,
  output logic [number_of_io-1:0] snapshot,
  output logic                    change_irq,
  output logic [number_of_io-1:0] pending,
  input  logic                    irq_ack,
  input  logic                    wr_req,
  input  logic [addr_size-1:0]    wr_idx,
  input  logic                    wr_val,
  output logic                    wr_ack,
  output logic                    busy
);

  localparam int CNT_W = (scan_period > 2) ? $clog2(scan_period) : 1;
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(scan_period - 1);
  localparam logic [addr_size-1:0] LAST_IDX = addr_size'(number_of_io - 1);
  localparam logic [addr_size:0]   NIO      = (addr_size + 1)'(number_of_io);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt;
  logic [addr_size-1:0]    scan_idx;
  logic [addr_size-1:0]    wr_idx_q;
  logic                    wr_val_q;
  logic [number_of_io-1:0] shadow;
  logic [number_of_io-1:0] shadow_cap;
  logic [number_of_io-1:0] pend_base;
  logic                    scan_last;
  logic                    wr_take;
  logic                    idx_ok;

  assign scan_last  = (scan_idx == LAST_IDX);
  // During the ack cycle the requester still holds wr_req; it must not
  // launch a second write.
  assign wr_take    = wr_req && !wr_ack;
  assign idx_ok     = ({1'b0, wr_idx_q} < NIO);
  assign busy       = (state != IDLE);
  assign change_irq = |pending;
  assign pend_base  = irq_ack ? '0 : pending;

  // Shadow including the line sampled this cycle, so the final capture and
  // the commit can share one edge.
  always_comb begin
    shadow_cap = shadow;
    for (int k = 0; k < number_of_io; k++) begin
      if (scan_idx == addr_size'(k)) shadow_cap[k] = io_gpi_read;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    io_addr      = '0;
    io_gpo_write = 1'b0;
    io_edit_gpo  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_take)                      state_next = WRITE;
        else if (cnt == '0 && enable)     state_next = SCAN;
      end
      SCAN: begin
        io_addr = scan_idx;
        // A write held through the scan runs right after the final capture.
        if (scan_last) state_next = wr_req ? WRITE : IDLE;
      end
      WRITE: begin
        io_addr      = wr_idx_q;
        io_gpo_write = wr_val_q;
        io_edit_gpo  = idx_ok;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= CNT_LOAD;
      scan_idx <= '0;
      shadow   <= '0;
      snapshot <= '0;
      pending  <= '0;
      wr_idx_q <= '0;
      wr_val_q <= 1'b0;
      wr_ack   <= 1'b0;
    end else begin
      wr_ack <= (state == WRITE);

      // Held at the reload value while busy so every return to IDLE restarts
      // the full period.
      if (state != IDLE)  cnt <= CNT_LOAD;
      else if (cnt != '0) cnt <= cnt - CNT_W'(1);

      if (state == SCAN && !scan_last) scan_idx <= scan_idx + addr_size'(1);
      else                             scan_idx <= '0;

      if (state == SCAN) shadow <= shadow_cap;

      if (state == SCAN && scan_last) begin
        snapshot <= shadow_cap;
        pending  <= pend_base | (shadow_cap ^ snapshot);
      end else begin
        pending  <= pend_base;
      end

      if (state_next == WRITE && state != WRITE) begin
        wr_idx_q <= wr_idx;
        wr_val_q <= wr_val;
      end
    end
  end

endmodule

// File: tb/tb_reflet_gpio_scanner.sv
module tb_reflet_gpio_scanner;

  localparam int NIO = 16;
  localparam int AW  = 6;
  localparam int SP  = 8;

  logic           clk = 1'b0;
  logic           reset, enable, io_gpi_read, io_gpo_write, io_edit_gpo;
  logic [AW-1:0]  io_addr, wr_idx;
  logic [NIO-1:0] snapshot, pending, gpi;
  logic           change_irq, irq_ack, wr_req, wr_val, wr_ack, busy;
  logic           probe;

  always #5 clk = ~clk;

  assign io_gpi_read = (io_addr < AW'(NIO)) ? gpi[io_addr[3:0]] : 1'b0;

  reflet_gpio_scanner #(.number_of_io(NIO), .addr_size(AW), .scan_period(SP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .io_addr(io_addr),
    .io_gpi_read(io_gpi_read), .io_gpo_write(io_gpo_write), .io_edit_gpo(io_edit_gpo),
    .snapshot(snapshot), .change_irq(change_irq), .pending(pending), .irq_ack(irq_ack),
    .wr_req(wr_req), .wr_idx(wr_idx), .wr_val(wr_val), .wr_ack(wr_ack), .busy(busy)
  );

  typedef enum {K_PROBE, K_COMMIT, K_EDIT, K_ACK, K_ABORT} kind_t;
  typedef struct {
    kind_t          kind;
    logic [NIO-1:0] snap;
    logic [NIO-1:0] pend;
    logic           irq;
    logic [AW-1:0]  addr;
    logic           val;
    int             gap;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input kind_t k, input logic [NIO-1:0] s, input logic [NIO-1:0] p,
                      input logic i, input logic [AW-1:0] a, input logic v, input int g);
    exp_t e;
    e.kind = k; e.snap = s; e.pend = p; e.irq = i; e.addr = a; e.val = v; e.gap = g;
    q.push_back(e);
  endtask

  task automatic take(input kind_t k, input string nm, output exp_t e, output bit ok);
    tests++;
    ok = 1'b0;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL %s: got unexpected %s event, expected nothing", nm, k.name());
    end else if (q[0].kind != k) begin
      fails++;
      $display("FAIL %s: got %s event, expected %s", nm, k.name(), q[0].kind.name());
      void'(q.pop_front());
    end else begin
      e  = q.pop_front();
      ok = 1'b1;
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an observable event.
  int   run = 0;
  int   idle_cnt = 0;
  int   gap_obs = 0;
  bit   pend_commit = 0;
  bit   commit_now;
  bit   ok;
  exp_t e;

  task automatic do_probe();
    exp_t pe;
    bit   pok;
    take(K_PROBE, "probe_order", pe, pok);
    if (pok) begin
      check("probe_snapshot", 32'(snapshot), 32'(pe.snap));
      check("probe_pending", 32'(pending), 32'(pe.pend));
      check("probe_change_irq", 32'(change_irq), 32'(pe.irq));
      check("probe_busy", 32'(busy), 32'(0));
      check("probe_io_addr", 32'(io_addr), 32'(0));
      check("probe_edit_gpo", 32'(io_edit_gpo), 32'(0));
      check("probe_gpo_write", 32'(io_gpo_write), 32'(0));
      check("probe_wr_ack", 32'(wr_ack), 32'(0));
    end
  endtask

  always @(negedge clk) begin
    commit_now = 1'b0;
    if (reset) begin
      if (q.size() > 0 && q[0].kind == K_ABORT) begin
        e = q.pop_front();
        check("abort_scan_cycle", 32'(run), 32'(e.gap));
      end
      if (probe) do_probe();
      run = 0; pend_commit = 1'b0; idle_cnt = 0;
    end else begin
      if (pend_commit) begin
        pend_commit = 1'b0;
        commit_now  = 1'b1;
        take(K_COMMIT, "commit_order", e, ok);
        if (ok) begin
          check("commit_snapshot", 32'(snapshot), 32'(e.snap));
          check("commit_pending", 32'(pending), 32'(e.pend));
          check("commit_change_irq", 32'(change_irq), 32'(e.irq));
          if (e.gap >= 0) check("scan_start_delay", 32'(gap_obs), 32'(e.gap));
        end
      end
      if (busy && !io_edit_gpo && io_addr == AW'(run)) begin
        if (run == 0) begin
          gap_obs = idle_cnt;
          check("scan_expected", 32'(q.size() > 0 && (q[0].kind == K_COMMIT || q[0].kind == K_ABORT)), 32'(1));
        end
        run++;
        if (run == NIO) begin run = 0; pend_commit = 1'b1; end
      end else begin
        run = 0;
      end
      if (busy) idle_cnt = 0;
      else      idle_cnt++;
      if (io_edit_gpo) begin
        take(K_EDIT, "edit_order", e, ok);
        if (ok) begin
          check("edit_io_addr", 32'(io_addr), 32'(e.addr));
          check("edit_gpo_write", 32'(io_gpo_write), 32'(e.val));
          if (e.gap == 1) check("write_follows_commit", 32'(commit_now), 32'(1));
        end
      end
      if (wr_ack) take(K_ACK, "wr_ack_order", e, ok);
      if (probe) do_probe();
    end
  end

  task automatic wait_busy(input logic lvl, input int lim, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (busy === lvl) seen = 1'b1;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s: got no busy=%0d within %0d cycles, expected it", nm, lvl, lim);
    end
  endtask

  task automatic wait_ack(input int lim, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (wr_ack === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s: got no wr_ack within %0d cycles, expected it", nm, lim);
    end
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  task automatic run_scan(input string nm);
    enable = 1'b1;
    wait_busy(1'b1, 200, nm);
    enable = 1'b0;
    wait_busy(1'b0, 40, nm);
  endtask

  task automatic do_write(input logic [AW-1:0] idx, input logic val, input bit in_range);
    if (in_range) push(K_EDIT, '0, '0, 1'b0, idx, val, 0);
    push(K_ACK, '0, '0, 1'b0, '0, 1'b0, 0);
    @(posedge clk); #1;
    wr_req = 1'b1; wr_idx = idx; wr_val = val;
    wait_ack(20, "write_ack_timeout");
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; gpi = 16'hABCD; irq_ack = 1'b0; probe = 1'b0;
    wr_req = 1'b0; wr_idx = '0; wr_val = 1'b0;

    // Reset values, then first scan against a zero snapshot.
    push(K_PROBE, 16'h0, 16'h0, 1'b0, '0, 1'b0, 0);
    repeat (2) @(posedge clk); #1 probe = 1'b1;
    @(posedge clk); #1 probe = 1'b0;
    push(K_COMMIT, 16'hABCD, 16'hABCD, 1'b1, '0, 1'b0, SP);
    reset = 1'b0;
    run_scan("scan1_timeout");

    // Acknowledge clears pending; one line falls.
    @(posedge clk); #1 irq_ack = 1'b1; gpi = 16'hABCC;
    @(posedge clk); #1 irq_ack = 1'b0;
    push(K_PROBE, 16'hABCD, 16'h0, 1'b0, '0, 1'b0, 0);
    probe = 1'b1;
    @(posedge clk); #1 probe = 1'b0;
    push(K_COMMIT, 16'hABCC, 16'h0001, 1'b1, '0, 1'b0, -1);
    run_scan("scan2_timeout");

    // Write in IDLE; the following scan waits a full period after it.
    do_write(AW'(7), 1'b1, 1'b1);
    push(K_COMMIT, 16'hABCC, 16'h0001, 1'b1, '0, 1'b0, SP);
    run_scan("scan3_timeout");

    // Write raised at scan cycle 3, irq_ack coinciding with the commit.
    gpi = 16'h1234;
    push(K_COMMIT, 16'h1234, 16'hB9F8, 1'b1, '0, 1'b0, -1);
    push(K_EDIT, '0, '0, 1'b0, AW'(10), 1'b0, 1);
    push(K_ACK, '0, '0, 1'b0, '0, 1'b0, 0);
    enable = 1'b1;
    wait_busy(1'b1, 200, "scan4_timeout");
    enable = 1'b0;
    repeat (3) @(posedge clk); #1;
    wr_req = 1'b1; wr_idx = AW'(10); wr_val = 1'b0;
    repeat (12) @(posedge clk); #1 irq_ack = 1'b1;
    @(posedge clk); #1 irq_ack = 1'b0;
    wait_ack(20, "scan4_ack_timeout");

    // Out-of-range write, then writes with scanning disabled.
    do_write(AW'(20), 1'b1, 1'b0);
    repeat (12) @(posedge clk);
    do_write(AW'(3), 1'b1, 1'b1);
    repeat (3 * SP + 16) @(posedge clk);

    // Reset in scan cycle 5: nothing committed, next scan a full period later.
    push(K_ABORT, '0, '0, 1'b0, '0, 1'b0, 5);
    push(K_PROBE, 16'h0, 16'h0, 1'b0, '0, 1'b0, 0);
    enable = 1'b1;
    wait_busy(1'b1, 200, "scan6_timeout");
    repeat (5) @(posedge clk); #1 reset = 1'b1; probe = 1'b1;
    @(posedge clk); #1 probe = 1'b0;
    push(K_COMMIT, 16'h1234, 16'h1234, 1'b1, '0, 1'b0, SP);
    @(posedge clk); #1 reset = 1'b0;
    run_scan("scan7_timeout");

    repeat (5) @(posedge clk);
    check("leftover_expectations", 32'(q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
